execute_md: RTL and testbench

//  Parametrised execute stage: forwarding, ALU, branch resolution, EX/MEM register, plus iterative M-extension unit.

---
 rtl/exe_pkg.sv | 52 +++++
 rtl/execute_md_muldiv.sv | 159 +++++++++++++++
 rtl/execute_md.sv | 184 ++++++++++++++++++
 tb/tb_execute_md.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared types and constants for the execute_md stage
// Contents: md_op_e (M-extension funct3), md_state_e (mul/div FSM),
// fwd_sel_e (operand forwarding select), ALU op and branch-type codes.
package exe_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // alu_op_exe[2:0]; alu_op_exe[3] selects SUB for ALU_ADD and SRA for ALU_SR
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SLL  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SR   = 3'd5;
    localparam logic [2:0] ALU_OR   = 3'd6;
    localparam logic [2:0] ALU_AND  = 3'd7;

    localparam logic [3:0] BJ_NONE = 4'd0;
    localparam logic [3:0] BJ_BEQ  = 4'd1;
    localparam logic [3:0] BJ_BNE  = 4'd2;
    localparam logic [3:0] BJ_BLT  = 4'd3;
    localparam logic [3:0] BJ_BGE  = 4'd4;
    localparam logic [3:0] BJ_BLTU = 4'd5;
    localparam logic [3:0] BJ_BGEU = 4'd6;
    localparam logic [3:0] BJ_JUMP = 4'd7;

    function automatic logic md_is_mul(md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU};
    endfunction

endpackage

// File: rtl/execute_md_muldiv.sv
// rtl/execute_md_muldiv.sv - iterative radix-2 multiply/divide unit (muldiv_unit)
// Ports: clk, rst_n (async active-low), start_i (accepted only in IDLE),
// op_i (md funct3), a_i/b_i operands, ack_i (result consumed in DONE),
// idle_o, done_o, result_o (valid while done_o).
// Macro EXE_FAST_MUL_EN: MUL* ops use a single-cycle multiply, IDLE->DONE.
module muldiv_unit
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            ack_i,
    output logic            idle_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN);

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic             neg_q, neg_d;

    md_op_e          op_in;
    logic            sa, sb, start_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    // Operands are reduced to magnitudes; the sign is reapplied at DONE.
    always_comb begin
        op_in = md_op_e'(op_i);
        sa    = a_i[XLEN-1] & (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
        sb    = b_i[XLEN-1] & (op_in inside {MD_MULH, MD_DIV, MD_REM});
        mag_a = sa ? -a_i : a_i;
        mag_b = sb ? -b_i : b_i;
        case (op_in)
            MD_MULH:   start_neg = sa ^ sb;
            MD_MULHSU: start_neg = sa;
            // divide by zero keeps the all-ones quotient unsigned
            MD_DIV:    start_neg = (sa ^ sb) & (b_i != '0);
            MD_REM:    start_neg = sa;
            default:   start_neg = 1'b0;
        endcase
    end

`ifdef EXE_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

    // Multiply: {hi,lo} is a right-shifting accumulator with lo holding the multiplier.
    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient in.
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;

    always_comb begin
        add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d    = op_in;
                    neg_d   = start_neg;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = mag_a;
                    b_d     = mag_b;
                    state_d = BUSY;
`ifdef EXE_FAST_MUL_EN
                    if (md_is_mul(op_in)) begin
                        {hi_d, lo_d} = fast_prod;
                        state_d      = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                if (md_is_mul(op_q)) begin
                    hi_d = add_sum[XLEN:1];
                    lo_d = {add_sum[0], lo_q[XLEN-1:1]};
                end else if (!div_diff[XLEN+1]) begin
                    hi_d = div_diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= MD_MUL;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
        end
    end

    logic [2*XLEN-1:0] prod_fix;

    always_comb begin
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        if (op_q == MD_MUL) begin
            result_o = prod_fix[XLEN-1:0];
        end else if (md_is_mul(op_q)) begin
            result_o = prod_fix[2*XLEN-1:XLEN];
        end else if (op_q inside {MD_DIV, MD_DIVU}) begin
            result_o = neg_q ? -lo_q : lo_q;
        end else begin
            result_o = neg_q ? -hi_q : hi_q;
        end
    end

    assign idle_o = (state_q == IDLE);
    assign done_o = (state_q == DONE);

endmodule

// File: rtl/execute_md.sv
// rtl/execute_md.sv - execute stage: forwarding, ALU, branch resolution, EX/MEM register, mul/div
// Ports: clk, rst_n (async active-low); ID/EX inputs (valid_exe, next_pc_exe, reg1, reg2,
// imm, alu_op_exe, bj_inst_exe, md_en_exe, md_op_exe, data_sel_exe, jalr_exe, lui_ex,
// forward_control1/2, wbdata_wb_ex, wrt_dst_exe, reg_wrt_en_exe, ctrl_exe); stall_mem in;
// stall_exe, branch, branch_pc out; EX/MEM register outputs *_mem.
// Macro EXE_FAST_MUL_EN (in muldiv_unit): single-cycle MUL* ops.
module execute_md
    import exe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_exe,
    input  logic [XLEN-1:0]   next_pc_exe,
    input  logic [XLEN-1:0]   reg1,
    input  logic [XLEN-1:0]   reg2,
    input  logic [XLEN-1:0]   imm,
    input  logic [3:0]        alu_op_exe,
    input  logic [3:0]        bj_inst_exe,
    input  logic              md_en_exe,
    input  logic [2:0]        md_op_exe,
    input  logic              data_sel_exe,
    input  logic              jalr_exe,
    input  logic              lui_ex,
    input  logic [1:0]        forward_control1,
    input  logic [1:0]        forward_control2,
    input  logic [XLEN-1:0]   wbdata_wb_ex,
    input  logic [REG_AW-1:0] wrt_dst_exe,
    input  logic              reg_wrt_en_exe,
    input  logic [CTRL_W-1:0] ctrl_exe,
    input  logic              stall_mem,
    output logic              stall_exe,
    output logic              branch,
    output logic [XLEN-1:0]   branch_pc,
    output logic              valid_mem,
    output logic [XLEN-1:0]   alu_result_mem,
    output logic [XLEN-1:0]   write_data_mem,
    output logic [XLEN-1:0]   next_pc_mem,
    output logic [REG_AW-1:0] wrt_dst_mem,
    output logic              reg_wrt_en_mem,
    output logic [CTRL_W-1:0] ctrl_mem
);

    localparam int SH_W = $clog2(XLEN);

    logic              valid_q, valid_d, reg_wrt_en_q, reg_wrt_en_d;
    logic [XLEN-1:0]   result_q, result_d, wdata_q, wdata_d, npc_q, npc_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic [XLEN-1:0]   op_a, fwd_b, op_b, alu_res, target;
    logic [SH_W-1:0]   shamt;
    logic [XLEN-1:0]   sra_res;
    logic              bj_taken, stall_int;

    always_comb begin
        case (fwd_sel_e'(forward_control1))
            FWD_WB:  op_a = wbdata_wb_ex;
            FWD_MEM: op_a = result_q;
            default: op_a = reg1;
        endcase
        case (fwd_sel_e'(forward_control2))
            FWD_WB:  fwd_b = wbdata_wb_ex;
            FWD_MEM: fwd_b = result_q;
            default: fwd_b = reg2;
        endcase
        op_b = (data_sel_exe && fwd_sel_e'(forward_control2) == FWD_REG) ? imm : fwd_b;
    end

    assign shamt   = op_b[SH_W-1:0];
    assign sra_res = $unsigned($signed(op_a) >>> shamt);

    always_comb begin
        case (alu_op_exe[2:0])
            ALU_ADD:  alu_res = alu_op_exe[3] ? op_a - op_b : op_a + op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SR:   alu_res = alu_op_exe[3] ? sra_res : op_a >> shamt;
            ALU_OR:   alu_res = op_a | op_b;
            default:  alu_res = op_a & op_b;
        endcase
        if (lui_ex) begin
            alu_res = op_b;
        end
    end

    // Branch compares the forwarded register pair, never the immediate.
    always_comb begin
        case (bj_inst_exe)
            BJ_BEQ:  bj_taken = (op_a == fwd_b);
            BJ_BNE:  bj_taken = (op_a != fwd_b);
            BJ_BLT:  bj_taken = ($signed(op_a) < $signed(fwd_b));
            BJ_BGE:  bj_taken = ($signed(op_a) >= $signed(fwd_b));
            BJ_BLTU: bj_taken = (op_a < fwd_b);
            BJ_BGEU: bj_taken = (op_a >= fwd_b);
            BJ_JUMP: bj_taken = 1'b1;
            default: bj_taken = 1'b0;
        endcase
        target = (jalr_exe ? op_a : next_pc_exe) + imm;
    end

    logic            md_req, md_idle, md_done;
    logic [XLEN-1:0] md_result;

    assign md_req = valid_exe & md_en_exe;

    muldiv_unit #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_req & ~stall_mem),
        .op_i     (md_op_exe),
        .a_i      (op_a),
        .b_i      (fwd_b),
        .ack_i    (~stall_mem),
        .idle_o   (md_idle),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // EX is occupied from the cycle an M op is seen until its result leaves DONE.
    assign stall_int = (md_idle & md_req) | (~md_idle & ~md_done) | (md_done & stall_mem);
    assign stall_exe = rst_n & stall_int;
    assign branch    = rst_n & valid_exe & ~stall_int & ~md_en_exe & bj_taken;
    assign branch_pc = {target[XLEN-1:1], target[0] & ~jalr_exe};

    always_comb begin
        valid_d      = valid_q;
        result_d     = result_q;
        wdata_d      = wdata_q;
        npc_d        = npc_q;
        dst_d        = dst_q;
        reg_wrt_en_d = reg_wrt_en_q;
        ctrl_d       = ctrl_q;
        if (!stall_mem) begin
            if (md_done || (md_idle && !md_req)) begin
                valid_d      = valid_exe;
                result_d     = md_done ? md_result : alu_res;
                wdata_d      = fwd_b;
                npc_d        = next_pc_exe;
                dst_d        = wrt_dst_exe;
                reg_wrt_en_d = reg_wrt_en_exe & valid_exe;
                ctrl_d       = ctrl_exe;
            end else begin
                valid_d      = 1'b0;
                reg_wrt_en_d = 1'b0;
                ctrl_d       = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            wdata_q      <= '0;
            npc_q        <= '0;
            dst_q        <= '0;
            reg_wrt_en_q <= 1'b0;
            ctrl_q       <= '0;
        end else begin
            valid_q      <= valid_d;
            result_q     <= result_d;
            wdata_q      <= wdata_d;
            npc_q        <= npc_d;
            dst_q        <= dst_d;
            reg_wrt_en_q <= reg_wrt_en_d;
            ctrl_q       <= ctrl_d;
        end
    end

    assign valid_mem      = valid_q;
    assign alu_result_mem = result_q;
    assign write_data_mem = wdata_q;
    assign next_pc_mem    = npc_q;
    assign wrt_dst_mem    = dst_q;
    assign reg_wrt_en_mem = reg_wrt_en_q;
    assign ctrl_mem       = ctrl_q;

endmodule

// File: tb/tb_execute_md.sv
// tb/tb_execute_md.sv - directed self-checking bench for execute_md (XLEN=32)
module tb_execute_md;

`ifdef EXE_FAST_MUL_EN
    localparam int MUL_CYC = 1;
`else
    localparam int MUL_CYC = 33;
`endif
    localparam int DIV_CYC = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_exe;
    logic [31:0] next_pc_exe, reg1, reg2, imm, wbdata_wb_ex;
    logic [3:0]  alu_op_exe, bj_inst_exe;
    logic        md_en_exe;
    logic [2:0]  md_op_exe;
    logic        data_sel_exe, jalr_exe, lui_ex;
    logic [1:0]  forward_control1, forward_control2;
    logic [4:0]  wrt_dst_exe;
    logic        reg_wrt_en_exe;
    logic [11:0] ctrl_exe;
    logic        stall_mem;
    logic        stall_exe, branch, valid_mem, reg_wrt_en_mem;
    logic [31:0] branch_pc, alu_result_mem, write_data_mem, next_pc_mem;
    logic [4:0]  wrt_dst_mem;
    logic [11:0] ctrl_mem;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    execute_md dut (
        .clk(clk), .rst_n(rst_n), .valid_exe(valid_exe), .next_pc_exe(next_pc_exe),
        .reg1(reg1), .reg2(reg2), .imm(imm), .alu_op_exe(alu_op_exe),
        .bj_inst_exe(bj_inst_exe), .md_en_exe(md_en_exe), .md_op_exe(md_op_exe),
        .data_sel_exe(data_sel_exe), .jalr_exe(jalr_exe), .lui_ex(lui_ex),
        .forward_control1(forward_control1), .forward_control2(forward_control2),
        .wbdata_wb_ex(wbdata_wb_ex), .wrt_dst_exe(wrt_dst_exe),
        .reg_wrt_en_exe(reg_wrt_en_exe), .ctrl_exe(ctrl_exe), .stall_mem(stall_mem),
        .stall_exe(stall_exe), .branch(branch), .branch_pc(branch_pc),
        .valid_mem(valid_mem), .alu_result_mem(alu_result_mem),
        .write_data_mem(write_data_mem), .next_pc_mem(next_pc_mem),
        .wrt_dst_mem(wrt_dst_mem), .reg_wrt_en_mem(reg_wrt_en_mem), .ctrl_mem(ctrl_mem)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic clear_in();
        valid_exe = 0; next_pc_exe = 0; reg1 = 0; reg2 = 0; imm = 0; alu_op_exe = 0;
        bj_inst_exe = 0; md_en_exe = 0; md_op_exe = 0; data_sel_exe = 0; jalr_exe = 0;
        lui_ex = 0; forward_control1 = 0; forward_control2 = 0; wbdata_wb_ex = 0;
        wrt_dst_exe = 0; reg_wrt_en_exe = 0; ctrl_exe = 0; stall_mem = 0;
    endtask

    // Entered and left on a falling edge; result checked one cycle after it leaves EX.
    task automatic alu_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input string tag);
        valid_exe = 1; alu_op_exe = op; reg1 = a; reg2 = b;
        @(negedge clk);
        chk(tag, alu_result_mem, exp);
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] fwd1, input logic [31:0] exp,
                          input int exp_cyc, input string tag);
        int cyc;
        cyc = 0;
        valid_exe = 1; md_en_exe = 1; md_op_exe = op; reg1 = a; reg2 = b;
        forward_control1 = fwd1; reg_wrt_en_exe = 1; wrt_dst_exe = 5'd9;
        #1;
        while (stall_exe && cyc < 100) begin
            cyc++;
            @(negedge clk);
            if (cyc == 2) chk({tag, " bubble"}, 32'(valid_mem), 32'd0);
            if (cyc == 3) begin
                reg1 = ~a; forward_control1 = 2'b01; wbdata_wb_ex = 32'hDEAD_BEEF;
            end
            #1;
        end
        chk({tag, " stall cycles"}, 32'(cyc), 32'(exp_cyc));
        @(negedge clk);
        valid_exe = 0; md_en_exe = 0; forward_control1 = 0;
        chk(tag, alu_result_mem, exp);
        chk({tag, " valid"}, 32'(valid_mem), 32'd1);
    endtask

    initial begin
        int cyc;
        clear_in();
        rst_n = 0;
        valid_exe = 1; bj_inst_exe = 4'd7;
        @(negedge clk); #1;
        chk("rst branch", 32'(branch), 32'd0);
        md_en_exe = 1; #1;
        chk("rst stall_exe", 32'(stall_exe), 32'd0);
        @(negedge clk);
        chk("rst valid_mem", 32'(valid_mem), 32'd0);
        chk("rst alu_result_mem", alu_result_mem, 32'd0);
        chk("rst ctrl_mem", 32'(ctrl_mem), 32'd0);
        chk("rst reg_wrt_en_mem", 32'(reg_wrt_en_mem), 32'd0);
        clear_in();
        rst_n = 1;
        @(negedge clk);

        // plain ALU ops, one-cycle latency
        valid_exe = 1; reg1 = 5; reg2 = 7; wrt_dst_exe = 5'd3; reg_wrt_en_exe = 1;
        ctrl_exe = 12'hABC; next_pc_exe = 32'h44; #1;
        chk("add stall_exe", 32'(stall_exe), 32'd0);
        @(negedge clk);
        chk("add result", alu_result_mem, 32'd12);
        chk("add valid", 32'(valid_mem), 32'd1);
        chk("add dst", 32'(wrt_dst_mem), 32'd3);
        chk("add ctrl", 32'(ctrl_mem), 32'hABC);
        chk("add store data", write_data_mem, 32'd7);
        chk("add next_pc", next_pc_mem, 32'h44);
        alu_step(4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, "sub");
        data_sel_exe = 1; imm = 32'd2;
        alu_step(4'b0010, 32'hFFFF_FFFD, 32'd0, 32'd1, "slt imm");
        data_sel_exe = 0; imm = 0;
        alu_step(4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
        alu_step(4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
        lui_ex = 1; data_sel_exe = 1; imm = 32'h1234_5000;
        alu_step(4'b0000, 32'd1, 32'd1, 32'h1234_5000, "lui");
        clear_in();

        // branches: combinational redirect
        valid_exe = 1; next_pc_exe = 32'h104; imm = 32'h10; reg1 = 9; reg2 = 9;
        bj_inst_exe = 4'd1; #1;
        chk("beq taken", 32'(branch), 32'd1);
        chk("beq target", branch_pc, 32'h114);
        bj_inst_exe = 4'd2; #1;
        chk("bne not taken", 32'(branch), 32'd0);
        reg1 = 32'hFFFF_FFFF; reg2 = 1; bj_inst_exe = 4'd3; #1;
        chk("blt taken", 32'(branch), 32'd1);
        bj_inst_exe = 4'd5; #1;
        chk("bltu not taken", 32'(branch), 32'd0);
        reg1 = 9; reg2 = 0; forward_control2 = 2'b01; wbdata_wb_ex = 9; bj_inst_exe = 4'd1; #1;
        chk("beq fwd wb", 32'(branch), 32'd1);
        forward_control2 = 0; bj_inst_exe = 4'd7; jalr_exe = 1; reg1 = 32'h201; imm = 4; #1;
        chk("jalr target", branch_pc, 32'h204);
        @(negedge clk);
        clear_in();

        // multiply / divide
        run_md(3'd0, 32'hFFFF_FFFF, 32'd3, 2'b00, 32'hFFFF_FFFD, MUL_CYC, "mul");
        run_md(3'd3, 32'hFFFF_FFFF, 32'd3, 2'b00, 32'h0000_0002, MUL_CYC, "mulhu");
        run_md(3'd1, 32'hFFFF_FFFF, 32'd3, 2'b00, 32'hFFFF_FFFF, MUL_CYC, "mulh");
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 2'b00, 32'hFFFF_FFFD, DIV_CYC, "div -7/2");
        run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 2'b00, 32'hFFFF_FFFF, DIV_CYC, "rem -7/2");
        run_md(3'd4, 32'd9, 32'd0, 2'b00, 32'hFFFF_FFFF, DIV_CYC, "div 9/0");
        run_md(3'd6, 32'd9, 32'd0, 2'b00, 32'd9, DIV_CYC, "rem 9/0");
        run_md(3'd4, 32'hFFFF_FFF8, 32'd0, 2'b00, 32'hFFFF_FFFF, DIV_CYC, "div -8/0");
        run_md(3'd6, 32'hFFFF_FFF8, 32'd0, 2'b00, 32'hFFFF_FFF8, DIV_CYC, "rem -8/0");
        run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, DIV_CYC, "div min/-1");
        run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'd0, DIV_CYC, "rem min/-1");
        run_md(3'd5, 32'hFFFF_FFFF, 32'h10, 2'b00, 32'h0FFF_FFFF, DIV_CYC, "divu");
        run_md(3'd7, 32'hFFFF_FFFF, 32'h10, 2'b00, 32'hF, DIV_CYC, "remu");

        // forwarded MEM operand latched at start
        alu_step(4'b0000, 32'd20, 32'd20, 32'd40, "add 40");
        clear_in();
        run_md(3'd0, 32'h1111, 32'd2, 2'b10, 32'd80, MUL_CYC, "mul fwd mem");

        // stall_mem held at DONE
        valid_exe = 1; md_en_exe = 1; md_op_exe = 3'd5; reg1 = 100; reg2 = 7; #1;
        cyc = 0;
        while (stall_exe && cyc < 100) begin
            cyc++;
            @(negedge clk); #1;
        end
        chk("divu stall cycles", 32'(cyc), 32'(DIV_CYC));
        stall_mem = 1; #1;
        chk("done stall_exe", 32'(stall_exe), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold stall_exe", 32'(stall_exe), 32'd1);
            chk("hold result", alu_result_mem, 32'd80);
            chk("hold valid", 32'(valid_mem), 32'd0);
        end
        stall_mem = 0; #1;
        chk("release stall_exe", 32'(stall_exe), 32'd0);
        @(negedge clk);
        clear_in();
        chk("divu 100/7", alu_result_mem, 32'd14);
        chk("divu valid", 32'(valid_mem), 32'd1);

        // reset in the middle of BUSY
        valid_exe = 1; md_en_exe = 1; md_op_exe = 3'd4; reg1 = 1000; reg2 = 3;
        repeat (11) @(negedge clk);
        #1;
        chk("busy stall_exe", 32'(stall_exe), 32'd1);
        rst_n = 0; #1;
        chk("mid rst result", alu_result_mem, 32'd0);
        chk("mid rst stall_exe", 32'(stall_exe), 32'd0);
        @(negedge clk);
        clear_in();
        rst_n = 1;
        valid_exe = 1; reg1 = 1; reg2 = 2; #1;
        chk("post rst stall_exe", 32'(stall_exe), 32'd0);
        @(negedge clk);
        clear_in();
        chk("post rst add", alu_result_mem, 32'd3);
        chk("post rst valid", 32'(valid_mem), 32'd1);
        run_md(3'd5, 32'd1000, 32'd3, 2'b00, 32'd333, DIV_CYC, "divu after rst");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
